// File: rtl/systolic_loader.sv
`default_nettype none
// ============================================================================
// Module   : systolic_loader
// Brief    : Serial operand loader that drives the NOR systolic grid, waits
//            for it to settle and hands the captured output bit downstream.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_loader #(
  parameter int ROW    = 4,
  parameter int COLUMN = 8,
  parameter int SETTLE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              serIn,
  input  logic              serValid,
  output logic              serReady,
  output logic [ROW-1:0]    rowOut,
  output logic [COLUMN-1:0] colOut,
  input  logic              gridOut,
  output logic              result,
  output logic              resultValid,
  input  logic              resultReady,
  output logic              busy
);

  localparam int              C_NBITS       = ROW + COLUMN;
  localparam int              C_CNT_W       = (C_NBITS > 1) ? $clog2(C_NBITS) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST_BIT = C_CNT_W'(C_NBITS - 1);
  localparam logic [7:0]      C_SETTLE_LAST = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t               state_q;
  logic [C_CNT_W-1:0]   bitCnt_q;
  logic [7:0]           settleCnt_q;
  logic [C_NBITS-1:0]   shadow_q;
  logic [C_NBITS-1:0]   shadow_d;

  // Shift right so the first streamed bit ends up at shadow bit 0.
  assign shadow_d = {serIn, shadow_q[C_NBITS-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      bitCnt_q    <= '0;
      settleCnt_q <= '0;
      shadow_q    <= '0;
      rowOut      <= '0;
      colOut      <= '0;
      result      <= 1'b0;
      resultValid <= 1'b0;
      busy        <= 1'b0;
      serReady    <= 1'b1;
    end else if (clear) begin
      // Grid operands and last result are deliberately left untouched.
      state_q     <= S_LOAD;
      bitCnt_q    <= '0;
      settleCnt_q <= '0;
      resultValid <= 1'b0;
      busy        <= 1'b0;
      serReady    <= 1'b1;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (serValid) begin
            shadow_q <= shadow_d;
            if (bitCnt_q == C_LAST_BIT) begin
              rowOut      <= shadow_d[ROW-1:0];
              colOut      <= shadow_d[C_NBITS-1:ROW];
              bitCnt_q    <= '0;
              settleCnt_q <= '0;
              state_q     <= S_SETTLE;
              serReady    <= 1'b0;
              busy        <= 1'b1;
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          if (settleCnt_q == C_SETTLE_LAST) begin
            result      <= gridOut;
            resultValid <= 1'b1;
            state_q     <= S_HOLD;
          end else begin
            settleCnt_q <= settleCnt_q + 8'd1;
          end
        end
        S_HOLD: begin
          if (resultReady) begin
            state_q     <= S_LOAD;
            resultValid <= 1'b0;
            busy        <= 1'b0;
            serReady    <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_LOAD;
          bitCnt_q    <= '0;
          settleCnt_q <= '0;
          resultValid <= 1'b0;
          busy        <= 1'b0;
          serReady    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_loader.sv
`default_nettype none
// Bench for systolic_loader: vector table, directed corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_systolic_loader;

  localparam int ROW = 4, COLUMN = 8, SETTLE = 3, NB = ROW + COLUMN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, clear = 1'b0, serIn = 1'b0, serValid = 1'b0, resultReady = 1'b0;
  logic serReady, result, resultValid, busy, gridOut;
  logic [ROW-1:0] rowOut;
  logic [COLUMN-1:0] colOut;

  // Grid stand-in: NOR of every operand bit.
  assign gridOut = ~(|rowOut | |colOut);

  systolic_loader #(.ROW(ROW), .COLUMN(COLUMN), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .clear(clear), .serIn(serIn), .serValid(serValid),
    .serReady(serReady), .rowOut(rowOut), .colOut(colOut), .gridOut(gridOut),
    .result(result), .resultValid(resultValid), .resultReady(resultReady), .busy(busy));

  // Second instance with the shortest settle time.
  logic u1_reset = 1'b1, u1_serIn = 1'b0, u1_serValid = 1'b0, u1_resultReady = 1'b0;
  logic u1_serReady, u1_result, u1_resultValid, u1_busy, u1_gridOut;
  logic [ROW-1:0] u1_rowOut;
  logic [COLUMN-1:0] u1_colOut;
  assign u1_gridOut = ~(|u1_rowOut | |u1_colOut);

  systolic_loader #(.ROW(ROW), .COLUMN(COLUMN), .SETTLE(1)) dut1 (
    .clk(clk), .reset(u1_reset), .clear(1'b0), .serIn(u1_serIn), .serValid(u1_serValid),
    .serReady(u1_serReady), .rowOut(u1_rowOut), .colOut(u1_colOut), .gridOut(u1_gridOut),
    .result(u1_result), .resultValid(u1_resultValid), .resultReady(u1_resultReady),
    .busy(u1_busy));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h required %h", name, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] pk(input logic sr, input logic rv, input logic bz,
                                     input logic [3:0] r, input logic [7:0] c, input logic res);
    return {sr, rv, bz, r, c, res};
  endfunction

  // Reference model: phase 0 = accepting bits, 1 = settling, 2 = offering result.
  int         m_phase = 0;
  int         m_wait  = 0;
  logic       m_bits[$];
  logic [3:0] m_row = '0;
  logic [7:0] m_col = '0;
  logic       m_res = 1'b0;

  task automatic model_edge();
    if (reset) begin
      m_bits.delete(); m_phase = 0; m_row = '0; m_col = '0; m_res = 1'b0;
    end else if (clear) begin
      m_bits.delete(); m_phase = 0;
    end else begin
      case (m_phase)
        0: if (serValid) begin
          m_bits.push_back(serIn);
          if (m_bits.size() == NB) begin
            for (int i = 0; i < ROW; i++) m_row[i] = m_bits[i];
            for (int i = 0; i < COLUMN; i++) m_col[i] = m_bits[ROW+i];
            m_bits.delete();
            m_phase = 1;
            m_wait  = SETTLE;
          end
        end
        1: begin
          m_wait--;
          if (m_wait == 0) begin
            m_res   = ~(|m_row | |m_col);
            m_phase = 2;
          end
        end
        default: if (resultReady) m_phase = 0;
      endcase
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return pk(serReady, resultValid, busy, rowOut, colOut, result);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", {16'h0, dut_vec()},
        {16'h0, pk(m_phase == 0, m_phase == 2, m_phase != 0, m_row, m_col, m_res)});
  endtask

  task automatic idle();
    reset = 1'b0; clear = 1'b0; serValid = 1'b0; resultReady = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    serIn = b; serValid = 1'b1;
    step();
    serValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!resultValid && n < 20) begin step(); n++; end
    chk("drain_valid", {31'h0, resultValid}, 32'h1);
    resultReady = 1'b1; step(); resultReady = 1'b0;
  endtask

  typedef struct {
    logic rst, clr, sin, sv, rr;
    logic [15:0] exp;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    logic [11:0] stream;
    logic [11:0] bits;
    int n;

    // ---------------- table: row 4'hA, column 8'h5C, long HOLD ----------------
    stream = 12'h5CA;
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(1, 0, 0, 4'h0, 8'h00, 0)});
    for (int i = 0; i < NB; i++)
      tbl.push_back('{1'b0, 1'b0, stream[i], 1'b1, 1'b0,
                      (i < NB - 1) ? pk(1, 0, 0, 4'h0, 8'h00, 0) : pk(0, 0, 1, 4'hA, 8'h5C, 0)});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, pk(0, 0, 1, 4'hA, 8'h5C, 0)});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pk(0, 0, 1, 4'hA, 8'h5C, 0)});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, pk(0, 1, 1, 4'hA, 8'h5C, 0)});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'(i % 2), 1'b0, pk(0, 1, 1, 4'hA, 8'h5C, 0)});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pk(1, 0, 0, 4'hA, 8'h5C, 0)});

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; clear = tbl[i].clr; serIn = tbl[i].sin;
      serValid = tbl[i].sv; resultReady = tbl[i].rr;
      step();
      chk($sformatf("table[%0d]", i), {16'h0, dut_vec()}, {16'h0, tbl[i].exp});
    end
    idle();

    // ---------------- clear after 5 bits ----------------
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    clear = 1'b1; serValid = 1'b1; serIn = 1'b1; step(); clear = 1'b0; serValid = 1'b0;
    bits = 12'h3F1;
    for (int i = 0; i < NB - 1; i++) send_bit(bits[i]);
    chk("clear_keeps_ops", {20'h0, colOut, rowOut}, {20'h0, 8'h5C, 4'hA});
    chk("clear_still_loading", {31'h0, serReady}, 32'h1);
    send_bit(bits[NB-1]);
    chk("clear_new_ops", {20'h0, colOut, rowOut}, {20'h0, bits});
    drain();

    // ---------------- twelve zero bits: latency and result ----------------
    for (int i = 0; i < NB; i++) send_bit(1'b0);
    chk("zeros_ops", {20'h0, colOut, rowOut}, 32'h0);
    n = 0;
    while (!resultValid && n < 20) begin step(); n++; end
    chk("zeros_latency", n, SETTLE);
    chk("zeros_result", {31'h0, result}, 32'h1);
    resultReady = 1'b1; step(); resultReady = 1'b0;

    // ---------------- reset in SETTLE at settleCnt==1 ----------------
    for (int i = 0; i < NB; i++) send_bit(1'b1);
    step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_settle", {16'h0, dut_vec()}, {16'h0, pk(1, 0, 0, 4'h0, 8'h00, 0)});
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst_no_result", {31'h0, resultValid}, 32'h0);
    end

    // ---------------- SETTLE=1 instance ----------------
    u1_reset = 1'b0;
    bits = 12'h000;
    for (int i = 0; i < NB; i++) begin
      u1_serIn = 1'b0; u1_serValid = 1'b1;
      step();
    end
    u1_serValid = 1'b0;
    chk("s1_not_yet", {31'h0, u1_resultValid}, 32'h0);
    step();
    chk("s1_valid", {31'h0, u1_resultValid}, 32'h1);
    chk("s1_result", {31'h0, u1_result}, 32'h1);
    u1_resultReady = 1'b1; step(); u1_resultReady = 1'b0;
    chk("s1_back_to_load", {30'h0, u1_serReady, u1_resultValid}, 32'h2);

    // ---------------- randomized run ----------------
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      clear       = ($urandom_range(0, 59) == 0);
      serValid    = ($urandom_range(0, 9) < 7);
      serIn       = ($urandom_range(0, 3) == 0);
      resultReady = ($urandom_range(0, 9) < 4);
      step();
      chk("rand_excl", {31'h0, serReady & resultValid}, 32'h0);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_loader.md
SYSTOLIC_LOADER -- requirements
Module: systolic_loader

Purpose: upstream operand stage for the ROW x COLUMN NOR systolic grid. Deserialises operands, holds the grid inputs stable, waits SETTLE cycles, captures the grid output bit and hands it off with valid/ready.

Interface
REQ-001 SHALL have parameter ROW, default 4, meaning grid row-operand width.
REQ-002 SHALL have parameter COLUMN, default 8, meaning grid column-operand width.
REQ-003 SHALL have parameter SETTLE, default 3, range 1..255, meaning cycles the grid inputs are held before the output is sampled.
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 clear  input  1  synchronous abort; discards any partial load or pending result.
REQ-008 serIn  input  1  serial operand bit.
REQ-009 serValid  input  1  serIn is valid.
REQ-010 serReady  output  1  loader accepts a serial bit.
REQ-011 rowOut  output  ROW  drives grid inRow.
REQ-012 colOut  output  COLUMN  drives grid inColumn.
REQ-013 gridOut  input  1  grid out bit.
REQ-014 result  output  1  captured grid output.
REQ-015 resultValid  output  1  result is valid.
REQ-016 resultReady  input  1  consumer accepts result.
REQ-017 busy  output  1  high in SETTLE or HOLD.

Function
REQ-018 SHALL implement FSM states LOAD, SETTLE, HOLD; serReady=1 only in LOAD; resultValid=1 only in HOLD; busy=1 in SETTLE or HOLD.
REQ-019 In LOAD, a bit SHALL be accepted on each rising edge with serValid=1; bits SHALL shift into an internal shadow register of ROW+COLUMN bits, and bitCnt SHALL increment.
REQ-020 Stream order SHALL be: bits 0..ROW-1 form row operand LSB first, then bits ROW..ROW+COLUMN-1 form column operand LSB first.
REQ-021 rowOut/colOut SHALL change only on the edge that accepts bit ROW+COLUMN-1; that edge SHALL load both from the shadow register, clear bitCnt, clear settleCnt and enter SETTLE.
REQ-022 rowOut/colOut SHALL remain stable through SETTLE and HOLD and the following LOAD until the next complete load.
REQ-023 In SETTLE, settleCnt SHALL increment each cycle; on the edge where settleCnt==SETTLE-1, gridOut SHALL be registered into result and the FSM SHALL enter HOLD.
REQ-024 Latency: resultValid SHALL rise exactly SETTLE cycles after the edge that accepted the final operand bit.
REQ-025 In HOLD, result SHALL be stable; on an edge with resultReady=1 the FSM SHALL return to LOAD. resultValid and serReady SHALL never be high together.
REQ-026 serValid outside LOAD SHALL be ignored, with no state change.
REQ-027 clear=1 SHALL force LOAD, bitCnt=0, settleCnt=0 and resultValid=0 on that edge; rowOut/colOut/result SHALL keep their values.
REQ-028 clear SHALL take priority over a simultaneous serial accept or result handshake.
REQ-029 bitCnt SHALL be ceil(log2(ROW+COLUMN)) bits wide and SHALL never exceed ROW+COLUMN-1; settleCnt SHALL be 8 bits and SHALL never wrap.

Reset
REQ-030 reset=1 SHALL set state=LOAD, bitCnt=0, settleCnt=0, shadow=0, rowOut=0, colOut=0, result=0, resultValid=0 and busy=0; serReady SHALL be 1 from the first cycle after reset deasserts.
REQ-031 reset SHALL take priority over clear and all handshakes, including when asserted mid-load or mid-SETTLE.

Verification
REQ-032 Load 12 zero bits back-to-back with the real grid attached -> rowOut=4'h0, colOut=8'h00; resultValid rises 3 cycles after the last accept; result=1.
REQ-033 With a gridOut stub, stream row 4'hA then column 8'h5C (LSB first) -> rowOut=4'hA and colOut=8'h5C appear exactly on the 12th accept edge, with no change before it.
REQ-034 Hold resultReady=0 for 10 cycles in HOLD while toggling serValid -> result stable, serReady=0, no bits consumed; then resultReady=1 -> LOAD next cycle.
REQ-035 Assert clear after 5 bits accepted -> next load needs a full 12 bits; previous rowOut/colOut stay unchanged until the new load completes.
REQ-036 Assert reset in SETTLE at settleCnt=1 -> all outputs at reset values next cycle and no result produced; repeat with SETTLE=1 -> resultValid rises 1 cycle after the final accept.
